// File: rtl/acc_requant_if.sv
// Streaming bus of acc_requant: MAC samples in, requantised int8 results out.
interface acc_requant_if #(
   parameter int ACC_W = 16,
   parameter int OUT_W = 8
);
   logic signed [ACC_W-1:0] in_data;
   logic                    in_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (output in_data, output in_valid, output out_ready,
                   input  out_data, input  out_valid);
   modport slave  (input  in_data, input  in_valid, input  out_ready,
                   output out_data, output out_valid);
endinterface

// File: rtl/acc_requant.sv
// Dot-product accumulator with bias, scale, rounding shift, ReLU and int8
// saturation, followed by a small output FIFO that drops on overflow.
module acc_requant #(
   parameter int ACC_W      = 16,
   parameter int SUM_W      = 32,
   parameter int OUT_W      = 8,
   parameter int LEN_W      = 8,
   parameter int SCALE_W    = 16,
   parameter int SHIFT_W    = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic        [LEN_W-1:0]       cfg_len,
   input  logic signed [SUM_W-1:0]       cfg_bias,
   input  logic signed [SCALE_W-1:0]     cfg_scale,
   input  logic        [SHIFT_W-1:0]     cfg_shift,
   input  logic                          cfg_relu,
   acc_requant_if.slave                  bus,
   output logic                          busy,
   output logic                          drop_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PW = SUM_W + SCALE_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic        [LEN_W-1:0]   LEN_ONE  = 1;
   localparam logic        [SHIFT_W-1:0] SH_ONE   = 1;
   localparam logic        [AW:0]        CNT_ONE  = 1;
   localparam logic        [AW:0]        FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic signed [PW:0]        RND_ONE  = 1;
   localparam logic signed [PW:0]        SAT_MAX  = {{(PW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [PW:0]        SAT_MIN  = {{(PW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state_q;
   logic        [LEN_W-1:0]    len_q;
   logic        [LEN_W-1:0]    cnt_q;
   logic signed [SUM_W-1:0]    bias_q;
   logic signed [SCALE_W-1:0]  scale_q;
   logic        [SHIFT_W-1:0]  shift_q;
   logic                       relu_q;
   logic signed [SUM_W-1:0]    sum_q;
   logic signed [SUM_W-1:0]    sum1_p1_q;
   logic                       vld_p1_q;
   logic signed [PW-1:0]       prod_p2_q;
   logic                       vld_p2_q;
   logic        [AW-1:0]       wr_ptr_q;
   logic        [AW-1:0]       rd_ptr_q;
   logic        [AW:0]         count_q;
   logic                       drop_q;
   logic signed [OUT_W-1:0]    mem_q [FIFO_DEPTH];

   logic signed [SUM_W-1:0]    in_ext;
   logic signed [SUM_W-1:0]    sum_d;
   logic signed [SUM_W-1:0]    sum1_d;
   logic        [LEN_W-1:0]    last_idx;
   logic                       acc_fire;
   logic                       last_term;
   logic signed [PW-1:0]       mul_a;
   logic signed [PW-1:0]       mul_b;
   logic signed [PW-1:0]       prod_d;
   logic signed [OUT_W-1:0]    res_p2;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       push_ok;
   logic                       drop;

   // Round half toward +inf, then arithmetic shift; one guard bit absorbs the carry.
   function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p,
                                                      input logic [SHIFT_W-1:0] sh);
      logic signed [PW:0] t;
      logic signed [PW:0] half;
      t    = {p[PW-1], p};
      half = '0;
      if (sh != '0) half = RND_ONE <<< (sh - SH_ONE);
      return (t + half) >>> sh;
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_clamp(input logic signed [PW:0] r,
                                                         input logic relu);
      logic signed [PW:0] v;
      v = r;
      if (relu && v[PW]) v = '0;
      if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
      if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
      return v[OUT_W-1:0];
   endfunction

   always_comb begin
      in_ext    = {{(SUM_W-ACC_W){bus.in_data[ACC_W-1]}}, bus.in_data};
      acc_fire  = (state_q == RUN) && bus.in_valid && !start;
      last_idx  = (len_q == '0) ? '0 : len_q - LEN_ONE;
      last_term = (cnt_q == last_idx);
      sum_d     = sum_q + in_ext;
      sum1_d    = sum_d + bias_q;
      mul_a     = {{SCALE_W{sum1_p1_q[SUM_W-1]}}, sum1_p1_q};
      mul_b     = {{SUM_W{scale_q[SCALE_W-1]}}, scale_q};
      prod_d    = mul_a * mul_b;
      res_p2    = sat_clamp(round_shift(prod_p2_q, shift_q), relu_q);
      push      = vld_p2_q && !start;
      pop       = (count_q != '0) && bus.out_ready;
      full      = (count_q == FULL_CNT);
      push_ok   = push && (!full || pop);
      drop      = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         bias_q    <= '0;
         scale_q   <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         sum_q     <= '0;
         sum1_p1_q <= '0;
         vld_p1_q  <= 1'b0;
         prod_p2_q <= '0;
         vld_p2_q  <= 1'b0;
         drop_q    <= 1'b0;
      end else if (start) begin
         state_q  <= RUN;
         len_q    <= cfg_len;
         bias_q   <= cfg_bias;
         scale_q  <= cfg_scale;
         shift_q  <= cfg_shift;
         relu_q   <= cfg_relu;
         cnt_q    <= '0;
         sum_q    <= '0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         // S1: accumulate; final term folds in the bias and restarts the sum
         if (acc_fire) begin
            if (last_term) begin
               sum_q     <= '0;
               cnt_q     <= '0;
               sum1_p1_q <= sum1_d;
            end else begin
               sum_q <= sum_d;
               cnt_q <= cnt_q + LEN_ONE;
            end
         end
         vld_p1_q <= acc_fire && last_term;
         // S2: full-width scale product
         if (vld_p1_q) prod_p2_q <= prod_d;
         vld_p2_q <= vld_p1_q;
         if (drop) drop_q <= 1'b1;
      end
   end

   // S3: round/clamp result lands in the FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= res_p2;
   end

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign busy          = (cnt_q != '0) || vld_p1_q || vld_p2_q;
   assign drop_err      = drop_q;
   assign fifo_count    = count_q;
endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant: a reference model queues expected results
// as vectors complete; a negedge monitor pops them as the DUT hands data out.
module tb_acc_requant;
   localparam int ACC_W      = 16;
   localparam int SUM_W      = 32;
   localparam int OUT_W      = 8;
   localparam int LEN_W      = 8;
   localparam int SCALE_W    = 16;
   localparam int SHIFT_W    = 5;
   localparam int FIFO_DEPTH = 4;
   localparam int AW         = $clog2(FIFO_DEPTH);

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic        [LEN_W-1:0]   cfg_len;
   logic signed [SUM_W-1:0]   cfg_bias;
   logic signed [SCALE_W-1:0] cfg_scale;
   logic        [SHIFT_W-1:0] cfg_shift;
   logic                      cfg_relu;
   logic                      busy;
   logic                      drop_err;
   logic        [AW:0]        fifo_count;

   acc_requant_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dif ();

   acc_requant #(
      .ACC_W(ACC_W), .SUM_W(SUM_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
      .SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_len(cfg_len), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .bus(dif),
      .busy(busy), .drop_err(drop_err), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int sb[$];

   int     m_len, m_bias, m_scale, m_shift, m_relu, m_cnt;
   longint m_acc;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input longint acc);
      longint s, p, r;
      s = acc + m_bias;
      p = s * m_scale;
      r = p + ((m_shift > 0) ? (longint'(1) << (m_shift - 1)) : 64'sd0);
      r = r >>> m_shift;
      if (m_relu != 0 && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return int'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len, input int bias, input int scale,
                           input int shift, input int relu);
      cfg_len   = LEN_W'(len);
      cfg_bias  = SUM_W'(bias);
      cfg_scale = SCALE_W'(scale);
      cfg_shift = SHIFT_W'(shift);
      cfg_relu  = (relu != 0);
      start     = 1'b1;
      tick();
      start   = 1'b0;
      m_len   = (len == 0) ? 1 : len;
      m_bias  = bias;
      m_scale = scale;
      m_shift = shift;
      m_relu  = relu;
      m_acc   = 0;
      m_cnt   = 0;
   endtask

   task automatic send(input int x, input bit expect_out);
      dif.in_data  = ACC_W'(x);
      dif.in_valid = 1'b1;
      tick();
      dif.in_valid = 1'b0;
      m_acc += x;
      m_cnt++;
      if (m_cnt >= m_len) begin
         if (expect_out) sb.push_back(model(m_acc));
         m_acc = 0;
         m_cnt = 0;
      end
   endtask

   task automatic drain(input int budget);
      dif.out_ready = 1'b1;
      for (int i = 0; i < budget && !(sb.size() == 0 && !dif.out_valid); i++) tick();
      chk("drain_pending", sb.size(), 0);
      chk("drain_valid", dif.out_valid, 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, dif.out_valid, 0);
      chk({tag, "_out_data"}, $signed(dif.out_data), 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_drop_err"}, drop_err, 0);
      chk({tag, "_fifo_count"}, fifo_count, 0);
   endtask

   always @(negedge clk) begin
      if (!reset && dif.out_valid && dif.out_ready) begin
         if (sb.size() == 0) chk("unexpected_out", $signed(dif.out_data), -999);
         else                chk("out_data", $signed(dif.out_data), sb.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0;
      cfg_len = '0; cfg_bias = '0; cfg_scale = '0; cfg_shift = '0; cfg_relu = 1'b0;
      dif.in_data = '0; dif.in_valid = 1'b0; dif.out_ready = 1'b0;
      m_len = 1; m_bias = 0; m_scale = 0; m_shift = 0; m_relu = 0; m_acc = 0; m_cnt = 0;
      repeat (3) tick();
      chk_reset_state("rst");
      reset = 1'b0;
      tick();

      // Basic sum with latency and busy
      do_start(4, 0, 1, 0, 0);
      send(10, 1); send(-3, 1); send(7, 1); send(2, 1);
      chk("lat_e0_valid", dif.out_valid, 0);
      chk("lat_e0_busy", busy, 1);
      tick();
      chk("lat_e1_valid", dif.out_valid, 0);
      tick();
      chk("lat_e2_valid", dif.out_valid, 1);
      chk("lat_e2_busy", busy, 0);
      chk("lat_e2_count", fifo_count, 1);
      drain(20);

      // Rounding, then bias
      do_start(1, 0, 3, 2, 0);
      send(5, 1); send(-5, 1); send(-6, 1);
      drain(20);
      do_start(1, 100, 1, 0, 0);
      send(-90, 1);
      drain(20);

      // Saturation and ReLU
      do_start(2, 0, 1, 0, 0);
      send(16000, 1); send(16000, 1);
      send(-100, 1); send(-100, 1);
      drain(20);
      do_start(2, 0, 1, 0, 1);
      send(-100, 1); send(-100, 1);
      drain(20);

      // Overflow with backpressure: fifth result is dropped
      dif.out_ready = 1'b0;
      do_start(1, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) send(i, 1);
      send(5, 0);
      repeat (4) tick();
      chk("ovf_count", fifo_count, FIFO_DEPTH);
      chk("ovf_drop", drop_err, 1);
      drain(20);
      chk("ovf_drop_sticky", drop_err, 1);

      // Push and pop on the same edge while full
      dif.out_ready = 1'b0;
      do_start(1, 0, 1, 0, 0);
      chk("start_clears_drop", drop_err, 0);
      for (int i = 1; i <= 4; i++) send(i, 1);
      repeat (4) tick();
      chk("full_count", fifo_count, FIFO_DEPTH);
      send(9, 1);
      tick();
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      chk("pushpop_count", fifo_count, FIFO_DEPTH);
      chk("pushpop_drop", drop_err, 0);
      drain(20);

      // Abort a partial vector with start
      do_start(4, 0, 1, 0, 0);
      send(50, 1); send(50, 1);
      do_start(4, 0, 1, 0, 0);
      send(1, 1); send(2, 1); send(3, 1); send(4, 1);
      drain(20);

      // Reset mid-vector with FIFO occupied, then inputs ignored in IDLE
      dif.out_ready = 1'b0;
      do_start(1, 0, 1, 0, 0);
      send(7, 1);
      repeat (3) tick();
      chk("pre_rst_valid", dif.out_valid, 1);
      do_start(4, 0, 1, 0, 0);
      send(1, 1);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      tick();
      sb.delete();
      chk_reset_state("midrst");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(5, 0);
         chk("idle_busy", busy, 0);
      end
      repeat (4) tick();
      chk("idle_valid", dif.out_valid, 0);
      chk("idle_count", fifo_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/acc_requant.md
# acc_requant

Downstream consumer of the int8 MAC stage. Accumulates a configurable number of signed MAC results into one dot-product sum, then adds a bias and multiplies by a scale. It applies a rounding right-shift, optional ReLU and int8 saturation, and buffers results in a small output FIFO with a valid/ready handshake. The MAC stage has no backpressure, so every input beat is always accepted. Results that cannot be buffered are dropped and flagged.

## Interface
Parameters:
- ACC_W, 16, width of signed input sample (MAC accumulator width)
- SUM_W, 32, signed dot-product accumulator and bias width
- OUT_W, 8, signed output width
- LEN_W, 8, width of cfg_len
- SCALE_W, 16, signed scale width
- SHIFT_W, 5, shift amount width
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  latch cfg_*, enter RUN, abort partial work
- cfg_len  in  LEN_W  terms per dot product; 0 is treated as 1
- cfg_bias  in  SUM_W  signed bias added to each sum
- cfg_scale  in  SCALE_W  signed multiplier
- cfg_shift  in  SHIFT_W  rounding right-shift amount
- cfg_relu  in  1  clamp negative results to 0
- in_data  in  ACC_W  signed MAC result
- in_valid  in  1  in_data valid this cycle
- out_data  out  OUT_W  FIFO head, signed
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- busy  out  1  partial sum or pipeline entry in flight
- drop_err  out  1  sticky: result dropped on full FIFO
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- States: IDLE (after reset) and RUN. start in either state sets state to RUN. There is no exit to IDLE except reset.
- In IDLE, in_valid is ignored.
- start (any state):
  - Latches all cfg_*.
  - Clears sum, term counter and both pipeline valids.
  - Clears drop_err.
  - FIFO contents are kept.
  - An in_valid in the same cycle as start is ignored.
- RUN accumulate:
  - On in_valid, sum += sext(in_data) and cnt += 1.
  - On the final term (cnt == len-1), S1 register = sum + sext(in_data) + bias and S1 valid is set. sum and cnt are reset to 0 in the same edge, so the next vector can start on the following cycle with no bubble.
  - sum wraps at SUM_W; it does not saturate.
- S2:
  - prod = S1 × sext(scale), full SUM_W+SCALE_W signed width.
- S3 round/clamp:
  - r = (prod + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic (round half toward +∞).
  - If relu and r<0, then r=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Push the result to the FIFO.
- FIFO:
  - Pop on out_valid && out_ready.
  - Push when full with no pop in the same cycle: result discarded, drop_err set.
  - Push when full with a simultaneous pop: both succeed, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (cnt != 0) || S1 valid || S2 valid.

## Timing
- Reset values:
  - state=IDLE
  - out_valid=0, out_data=0, busy=0, drop_err=0, fifo_count=0
  - sum, cnt, pipeline registers and FIFO pointers = 0
- Latency: the final term is sampled at edge E0. S1 is valid after E0, S2 after E1, FIFO write at E2. out_valid is high in the cycle after E2, i.e. 3 edges after the final term.
- Throughput: one result per cycle is sustained when cfg_len=1.
- out_data is combinational from the FIFO head. It must hold stable while out_valid && !out_ready.
- Reset mid-operation: the next cycle matches the reset values exactly, and in-flight results are lost.

## Test plan
- Basic sum: len=4, bias=0, scale=1, shift=0. Drive inputs 10, -3, 7, 2 on consecutive cycles → out_data=16; out_valid rises 3 edges after the 4th beat; busy is low afterwards.
- Rounding and bias: len=1, scale=3, shift=2, bias=0. Inputs 5, -5, -6 → outputs 4, -4, -4. Then bias=100, scale=1, shift=0, input -90 → 10.
- Saturation and ReLU: len=2, scale=1, shift=0. Inputs 16000, 16000 → 127. Inputs -100, -100 → -128. With relu=1, inputs -100, -100 → 0.
- Backpressure and overflow: len=1, out_ready=0, five inputs 1..5 → fifo_count=4, drop_err=1. Then out_ready=1 → outputs 1, 2, 3, 4 in order, out_valid drops, drop_err stays 1 until start.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the same cycle as an S3 push → no drop, fifo_count stays 4.
- Abort and reset:
  - len=4: two terms (50, 50), then start, then terms 1, 2, 3, 4 → single output 10.
  - Assert reset mid-vector with the FIFO non-empty → all outputs at reset values the next cycle.
  - After reset, in_valid is ignored until start.
